// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the pipelined LEGv8 core: control-bundle layout,
// zero-register index and the bubble encoding.
package arm_pipe_pkg;

   localparam int CTRL_W        = 9;
   localparam int CTRL_REGWRITE = 8;
   localparam int CTRL_MEMREAD  = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_MEMTOREG = 5;
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_ALUOP_HI = 3;
   localparam int CTRL_ALUOP_LO = 2;
   localparam int CTRL_BRANCH   = 1;
   localparam int CTRL_UNCOND   = 0;

   localparam int ZR_IDX = 31;

   typedef logic [CTRL_W-1:0] ctrl_t;

   localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to produce. Purely combinational.
module hazard_detect
   import arm_pipe_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int ZR_IDX = arm_pipe_pkg::ZR_IDX
) (
   input  logic              rst,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   output logic              hz,
   output logic              stall
);

   localparam logic [REG_AW-1:0] ZR = REG_AW'(ZR_IDX);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1 && (ex_rd == id_rs1);
   assign rs2_hit = id_use_rs2 && (ex_rd == id_rs2);

   // A load into XZR produces nothing, so it can never stall a reader.
   assign hz    = ex_valid && ex_mem_read && (ex_rd != ZR) && (rs1_hit || rs2_hit);
   assign stall = hz && !flush && !rst;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID write-through bypass, load-use bubble
// insertion and a saturating stall-cycle counter.
module id_ex_stage
   import arm_pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5,
   parameter int ZR_IDX = arm_pipe_pkg::ZR_IDX,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rdata1,
   output logic [DATA_W-1:0] ex_rdata2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_valid,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [REG_AW-1:0] ZR = REG_AW'(ZR_IDX);

   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic              hz;

   // The register file commits WB on the same edge that captures ID, so the
   // value it returns is stale when WB targets the same register.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      op1 = id_rdata1;
      op2 = id_rdata2;
      if (wb_reg_write && (wb_rd == id_rs1) && (id_rs1 != ZR)) op1 = wb_data;
      if (wb_reg_write && (wb_rd == id_rs2) && (id_rs2 != ZR)) op2 = wb_data;
   end

   hazard_detect #(
      .REG_AW (REG_AW),
      .ZR_IDX (ZR_IDX)
   ) u_hazard_detect (
      .rst         (rst),
      .flush       (flush),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .hz          (hz),
      .stall       (stall)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_pc       <= '0;
         ex_rdata1   <= '0;
         ex_rdata2   <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= BUBBLE;
         ex_valid    <= 1'b0;
         stall_count <= '0;
      end else if (flush || hz) begin
         ex_pc     <= '0;
         ex_rdata1 <= '0;
         ex_rdata2 <= '0;
         ex_imm    <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_rd     <= '0;
         ex_ctrl   <= BUBBLE;
         ex_valid  <= 1'b0;
         // stall already excludes flush, so a flushed hazard is not counted.
         if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      end else begin
         ex_pc     <= id_pc;
         ex_rdata1 <= op1;
         ex_rdata2 <= op2;
         ex_imm    <= id_imm;
         ex_rs1    <= id_rs1;
         ex_rs2    <= id_rs2;
         ex_rd     <= id_rd;
         ex_ctrl   <= id_ctrl;
         ex_valid  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_id_ex_stage;
   import arm_pipe_pkg::*;

   localparam int DW = 64;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] id_pc, id_rdata1, id_rdata2, id_imm, wb_data;
   logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic          id_use_rs1, id_use_rs2, wb_reg_write, flush;
   logic [8:0]    id_ctrl;

   logic [DW-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
   logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic [8:0]    ex_ctrl;
   logic          ex_valid, stall;
   logic [31:0]   stall_count;

   logic [DW-1:0] s_pc, s_rdata1, s_rdata2, s_imm;
   logic [AW-1:0] s_rs1, s_rs2, s_rd;
   logic [8:0]    s_ctrl;
   logic          s_valid, s_stall;
   logic [3:0]    stall_count4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .ex_valid(ex_valid), .stall(stall), .stall_count(stall_count)
   );

   id_ex_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .ex_pc(s_pc), .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm),
      .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_ctrl(s_ctrl),
      .ex_valid(s_valid), .stall(s_stall), .stall_count(stall_count4)
   );

   // Reference model: what EX should hold, plus both stall counters.
   typedef struct packed {
      logic [DW-1:0] pc, r1, r2, imm;
      logic [AW-1:0] rs1, rs2, rd;
      logic [8:0]    ctrl;
      logic          valid;
   } ex_t;

   ex_t         m;
   logic [31:0] m_cnt;
   int          m_cnt4;
   logic        last_stall;

   localparam logic [8:0] C_LOAD = 9'b1_1_0_1_1_00_0_0;
   localparam logic [8:0] C_ALU  = 9'b1_0_0_0_0_10_0_0;

   task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_hz();
      logic reads_rd;
      reads_rd = (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
      return m.valid && m.ctrl[CTRL_MEMREAD] && (m.rd != 5'd31) && reads_rd;
   endfunction

   function automatic logic [DW-1:0] read_val(logic [AW-1:0] idx, logic [DW-1:0] rf);
      if (wb_reg_write && wb_rd == idx && idx != 5'd31) return wb_data;
      return rf;
   endfunction

   task automatic compare_all();
      check("ex_pc",     ex_pc,     m.pc);
      check("ex_rdata1", ex_rdata1, m.r1);
      check("ex_rdata2", ex_rdata2, m.r2);
      check("ex_imm",    ex_imm,    m.imm);
      check("ex_rs1",    ex_rs1,    m.rs1);
      check("ex_rs2",    ex_rs2,    m.rs2);
      check("ex_rd",     ex_rd,     m.rd);
      check("ex_ctrl",   ex_ctrl,   m.ctrl);
      check("ex_valid",  ex_valid,  m.valid);
      check("stall_count",  stall_count,  m_cnt);
      check("stall_count4", stall_count4, m_cnt4);
   endtask

   // Inputs are already driven; check stall before the edge, then clock and
   // compare registered outputs just after it.
   task automatic cycle();
      ex_t  nxt;
      logic hz, exp_stall;
      #2;
      hz        = model_hz();
      exp_stall = hz && !flush && !rst;
      last_stall = stall;
      check("stall", stall, exp_stall);
      nxt = '0;
      if (rst) begin
         m_cnt  = 0;
         m_cnt4 = 0;
      end else if (flush) begin
         // bubble, counters untouched
      end else if (hz) begin
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end else begin
         nxt.pc    = id_pc;
         nxt.r1    = read_val(id_rs1, id_rdata1);
         nxt.r2    = read_val(id_rs2, id_rdata2);
         nxt.imm   = id_imm;
         nxt.rs1   = id_rs1;
         nxt.rs2   = id_rs2;
         nxt.rd    = id_rd;
         nxt.ctrl  = id_ctrl;
         nxt.valid = 1'b1;
      end
      @(posedge clk);
      m = nxt;
      #1;
      compare_all();
   endtask

   task automatic set_instr(logic [AW-1:0] rs1, logic u1, logic [AW-1:0] rs2, logic u2,
                            logic [AW-1:0] rd, logic [DW-1:0] r1, logic [DW-1:0] r2,
                            logic [8:0] ctrl);
      id_pc      = {$urandom, $urandom};
      id_imm     = {$urandom, $urandom};
      id_rs1     = rs1;
      id_use_rs1 = u1;
      id_rs2     = rs2;
      id_use_rs2 = u2;
      id_rd      = rd;
      id_rdata1  = r1;
      id_rdata2  = r2;
      id_ctrl    = ctrl;
   endtask

   function automatic logic [AW-1:0] rand_idx();
      return ($urandom_range(0, 5) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
   endfunction

   task automatic rand_all(bit allow_flush);
      set_instr(rand_idx(), 1'($urandom), rand_idx(), 1'($urandom), rand_idx(),
                {$urandom, $urandom}, {$urandom, $urandom}, 9'($urandom));
      if (id_rs1 == 5'd31) id_rdata1 = '0;
      if (id_rs2 == 5'd31) id_rdata2 = '0;
      if ($urandom_range(0, 2) == 0) id_ctrl[CTRL_MEMREAD] = 1'b1;
      wb_reg_write = 1'($urandom);
      wb_rd        = rand_idx();
      wb_data      = {$urandom, $urandom};
      flush        = allow_flush && ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      m      = '0;
      m_cnt  = 0;
      m_cnt4 = 0;

      // Reset with random inputs for two cycles.
      rst = 1'b1;
      rand_all(1'b1);
      cycle();
      rand_all(1'b1);
      cycle();
      check("rst_valid", ex_valid, 1'b0);
      check("rst_cnt", stall_count, 32'd0);

      // First capture after release.
      rst = 1'b0;
      rand_all(1'b0);
      id_ctrl = C_ALU;
      cycle();
      check("first_capture_valid", ex_valid, 1'b1);

      // WB bypass onto rs1, then the XZR case.
      set_instr(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 64'd5, 64'd6, C_ALU);
      wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD; flush = 1'b0;
      cycle();
      check("bypass_dead", ex_rdata1, 64'hDEAD);
      set_instr(5'd31, 1'b1, 5'd6, 1'b1, 5'd7, 64'd0, 64'd6, C_ALU);
      wb_rd = 5'd31;
      cycle();
      check("bypass_xzr", ex_rdata1, 64'd0);
      wb_reg_write = 1'b0;

      // Load-use: LDUR X3, then ADD reading X3 -> one bubble, then capture.
      set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 64'h100, 64'd0, C_LOAD);
      cycle();
      set_instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 64'h11, 64'h22, C_ALU);
      cycle();
      check("lu_stall", last_stall, 1'b1);
      check("lu_bubble_ctrl", ex_ctrl, 9'd0);
      check("lu_bubble_valid", ex_valid, 1'b0);
      check("lu_count", stall_count, 32'd1);
      cycle();
      check("lu_release_stall", last_stall, 1'b0);
      check("lu_release_rd", ex_rd, 5'd5);
      check("lu_release_valid", ex_valid, 1'b1);

      // Load into XZR never stalls a reader of XZR.
      set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd31, 64'h200, 64'd0, C_LOAD);
      cycle();
      set_instr(5'd31, 1'b1, 5'd0, 1'b0, 5'd8, 64'd0, 64'd0, C_ALU);
      cycle();
      check("xzr_no_stall", last_stall, 1'b0);
      check("xzr_valid", ex_valid, 1'b1);

      // Flush and hazard together: flush wins, counter unchanged.
      set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 64'h300, 64'd0, C_LOAD);
      cycle();
      set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 64'd1, 64'd0, C_ALU);
      flush = 1'b1;
      cycle();
      check("flush_no_stall", last_stall, 1'b0);
      check("flush_bubble_valid", ex_valid, 1'b0);
      check("flush_count_kept", stall_count, 32'd1);
      flush = 1'b0;

      // Twenty load-use pairs to saturate the 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         set_instr(5'd1, 1'b1, 5'd2, 1'b0, 5'd9, 64'h400, 64'd0, C_LOAD);
         cycle();
         set_instr(5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 64'd3, 64'd4, C_ALU);
         cycle();
      end
      check("sat_cnt4", stall_count4, 4'd15);
      check("sat_cnt32", stall_count, 32'd21);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rand_all(1'b1);
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the register file in the pipelined ARM (LEGv8-style, 64-bit, X31 = XZR) core.
- Captures the two read operands, immediate, destination and control bundle for EX.
- Provides a WB→ID write-through bypass, because the register file writes on the same posedge that ID samples.
- Detects load-use hazards, inserts bubbles and counts stall cycles.

Parameters:
- DATA_W, 64, operand/immediate/PC width
- REG_AW, 5, register index width
- ZR_IDX, 31, zero-register index; never a hazard or bypass source
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_pc  in  DATA_W  PC of the instruction in ID
- id_rs1, id_rs2  in  REG_AW  register file read indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  REG_AW  destination index
- id_rdata1, id_rdata2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[1:0], Branch, Uncond}
- wb_reg_write  in  1  WB write enable (same signal driving register file RegWrite)
- wb_rd  in  REG_AW  WB destination
- wb_data  in  DATA_W  WB write data
- flush  in  1  taken branch resolved; kill ID contents
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  DATA_W  registered
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered
- ex_ctrl  out  9  registered control; all-zero = bubble
- ex_valid  out  1  EX holds a real instruction
- stall  out  1  combinational; holds PC and IF/ID
- stall_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (synchronous): all outputs zero at the first posedge with rst=1. stall_count=0, ex_valid=0. stall is forced 0 while rst=1.
- Bypass (combinational):
  - op1 = wb_data when wb_reg_write && wb_rd==id_rs1 && id_rs1!=ZR_IDX; otherwise id_rdata1.
  - op2 is formed the same way from id_rs2 and id_rdata2.
  - An index equal to ZR_IDX always reads id_rdata*, which the register file guarantees is 0.
- Hazard (combinational):
  - hz = ex_valid && ex_ctrl.MemRead && ex_rd!=ZR_IDX && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
  - stall = hz && !flush && !rst.
- Update at each posedge, in priority order:
  - rst: clear everything.
  - flush: bubble. ex_ctrl=0, ex_valid=0, data/index fields=0. stall_count unchanged.
  - hz: bubble as for flush. stall_count+=1, saturating at all-ones.
  - Otherwise: capture the ID bundle with op1/op2 into ex_*, and set ex_valid=1.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs. No internal state other than the pipeline register and the counter.
- Load-use takes exactly one bubble. On the next cycle the load has left EX, so hz deasserts unless a new load is present.
- flush and hz in the same cycle: flush wins, no stall, and the counter does not increment.
- Bypass and hazard on the same index in the same cycle are independent. The bypass value is captured only when no bubble is inserted.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - control-bundle field offsets (CTRL_REGWRITE … CTRL_UNCOND) and CTRL_W=9
  - ZR_IDX
  - the BUBBLE constant (all-zero control)
- Natural sub-module: hazard_detect (pure combinational hz/stall), reusable by the IF/ID stage.
- The bypass muxes stay inline.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs → all ex_* = 0, stall=0, stall_count=0; after release, the first capture appears 1 cycle later.
- WB bypass: id_rs1=5, id_rdata1=5, wb_reg_write=1, wb_rd=5, wb_data=0xDEAD → next cycle ex_rdata1=0xDEAD. Repeat with wb_rd=31 and id_rs1=31 → ex_rdata1=0.
- Load-use, sequenced over cycles:
  - Cycle N: capture LDUR X3 (MemRead=1, id_rd=3).
  - Cycle N+1: present ADD reading X3, id_use_rs1=1 → stall=1 in that cycle; at the posedge that follows, ex_ctrl=0, ex_valid=0 and stall_count=1.
  - Cycle N+2: the ADD is still held in ID → stall=0; at the next posedge it is captured into EX.
- XZR load: LDUR with id_rd=31 followed by a reader of rs1=31 → stall never asserts.
- Flush priority: hz and flush both asserted in the same cycle → stall=0, bubble inserted, stall_count unchanged.
- Counter saturation: CNT_W=4 override, force 20 load-use hazards → stall_count holds at 15.
